ddr_dqs_wr_seq: RTL and testbench
=================================

# ddr_dqs_wr_seq

Write-burst sequencer for one LPDDR4 byte lane. It takes write-command pulses with a programmable write latency. Each cycle it generates the 8-phase DQS SDR pattern, plus the DQ write-data enable, that feed the DQS/DQ transmit path of `dfi2dp` (`i_tx_dqs0_sdr` / `i_tx_dqs1_sdr`, one instance per lane). It handles preamble/postamble insertion, seamless back-to-back bursts, and queuing of up to `DEPTH` in-flight writes.

## Interface
Parameters:
- `LAT_W`, 6: width of write-latency field (cycles).
- `DEPTH`, 4: pending-burst queue entries (power of 2, ≥2).

Ports:
- `i_clk`  in  1  core clock, one DFI cycle = 8 phases.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_wr_cmd`  in  1  write-command pulse, one per burst.
- `i_wr_lat`  in  LAT_W  cycles from command to first data cycle; sampled with `i_wr_cmd`.
- `i_bl32`  in  1  1 = BL32 (4 data cycles), 0 = BL16 (2 data cycles); sampled with `i_wr_cmd`.
- `o_tx_dqs_sdr`  out  8  DQS phase pattern, bit 0 = earliest phase.
- `o_dqs_oe`  out  1  DQS driver enable.
- `o_wrdata_en`  out  1  DQ data cycle qualifier.
- `o_busy`  out  1  queue non-empty or burst in progress.
- `o_err`  out  1  one-cycle pulse: command rejected.

## Operation
- Free-running cycle counter, `LAT_W+1` bits, wraps.
  - Accepted command stores `{start = cnt + i_wr_lat, bl32}` in the FIFO.
  - All start/end comparisons use wrap-safe subtraction.
- Timing frame: edge E0 samples the command; cycle k is the period after edge Ek.
  - Burst with latency L and N data cycles occupies: preamble cycle L-1, data cycles L..L+N-1, postamble cycle L+N.
- Patterns:
  - idle 8'h00;
  - preamble 8'b1010_0000;
  - data 8'b1010_1010;
  - postamble 8'b0000_0010.
- `o_dqs_oe` is 1 from preamble through postamble inclusive.
- `o_wrdata_en` is 1 only in data cycles.
- FSM states: IDLE, PRE, DATA, POST.
  - IDLE→PRE when the head entry's start == next cycle + 1.
  - PRE→DATA unconditionally.
  - DATA stays N cycles, then goes to DATA, PRE or POST:
    - →DATA (seamless): head start == end+1. The head is popped; no postamble or preamble is emitted.
    - →PRE: head start == end+2. The postamble is replaced by the preamble.
    - →POST: otherwise.
  - POST→PRE if head start == next cycle + 1, else →IDLE.
- A burst is popped from the FIFO when its first data cycle begins.
- Rejection: `o_err` pulses in cycle 1 and the command is dropped, with no state change, when any of these holds:
  - `i_wr_lat` < 2;
  - FIFO full;
  - new start ≤ end cycle of the last accepted burst (overlap).
- The last-accepted end register resets to "none". A queued start equal to the last end + 1 is legal (seamless).
- Spacing rule: successive accepted starts must differ by < 2^LAT_W for the wrap-safe compare. Traffic must obey this; it is not checked.

## Timing
- Reset values: `o_tx_dqs_sdr`=8'h00, `o_dqs_oe`=0, `o_wrdata_en`=0, `o_busy`=0, `o_err`=0.
  - Reset also clears the FIFO, counter and last-end register.
- All outputs are registered. No combinational path from inputs to outputs.
- Minimum latency is L=2: preamble in cycle 1, data in cycle 2.
- `o_busy` goes 1 in cycle 1 after an accepted command. It goes 0 in the cycle after the final postamble.
- Reset asserted mid-burst forces all outputs to reset values immediately (asynchronously). Post-reset, no partial burst resumes.
- Simultaneous command acceptance and FIFO pop in one cycle are supported when the FIFO is full: the pop frees a slot the same cycle.

## Test plan
- BL16, L=5 at E0:
  - cycle 4 = 8'b1010_0000, oe=1;
  - cycles 5–6 = 8'hAA, wrdata_en=1;
  - cycle 7 = 8'b0000_0010;
  - cycle 8 idle, busy=0.
- Seamless: BL16 L=4 at E0, then BL32 L=4 at E2.
  - Data cycles 4–9 are continuous 8'hAA, with a single preamble (cycle 3) and a single postamble (cycle 10).
- Gap-of-one: BL16 L=4 at E0, then BL16 L=4 at E3.
  - Cycle 6 carries the preamble (not the postamble), oe stays 1, and data resumes in cycle 7.
- Errors:
  - L=1 → `o_err` pulse in cycle 1, no DQS activity.
  - Overlap: BL32 L=4 at E0, then L=4 at E1 → `o_err`; the first burst is unaffected.
- Queue full: 4 commands with L=40 at E0..E3 accepted; 5th at E4 → `o_err`.
  - Afterwards, the four bursts are emitted at their exact start cycles.
- Reset mid-DATA (at cycle 5 of the first scenario):
  - all outputs 0 immediately;
  - after release with no commands, outputs stay idle and busy=0.

Source files
------------

// File: rtl/ddr_dqs_wr_seq.sv
// Write-burst sequencer for one LPDDR4 byte lane: queues write commands by absolute
// start cycle and plays out DQS preamble/data/postamble patterns plus the DQ data enable.
//
// state  | meaning
// S_IDLE | DQS driver off, waiting for the head burst's preamble cycle
// S_PRE  | preamble cycle, driver on
// S_DATA | data cycles; back-to-back bursts chain here seamlessly
// S_POST | postamble cycle after the last data cycle
module ddr_dqs_wr_seq #(
  parameter int LAT_W = 6,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_cmd,
  input  logic [LAT_W-1:0] i_wr_lat,
  input  logic             i_bl32,
  output logic [7:0]       o_tx_dqs_sdr,
  output logic             o_dqs_oe,
  output logic             o_wrdata_en,
  output logic             o_busy,
  output logic             o_err
);

  localparam int CW = LAT_W + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [7:0] PAT_IDLE = 8'h00;
  localparam logic [7:0] PAT_PRE  = 8'b1010_0000;
  localparam logic [7:0] PAT_DATA = 8'b1010_1010;
  localparam logic [7:0] PAT_POST = 8'b0000_0010;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_POST} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_fifo_start [DEPTH];
  logic          r_fifo_bl32  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_last_end;
  logic          r_last_vld;
  logic [1:0]    r_beats_left;
  logic          r_err_d;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_reject;
  logic          w_overlap;
  logic          w_lat_bad;
  logic          w_head_now;
  logic          w_head_next;
  logic          w_busy_nxt;
  logic [CW-1:0] w_cnt_p1;
  logic [CW-1:0] w_head_start;
  logic          w_head_bl32;
  logic [CW-1:0] w_new_start;
  logic [CW-1:0] w_new_end;
  logic [CW-1:0] w_ovl_diff;

  function automatic logic [7:0] f_pattern(state_t s);
    case (s)
      S_PRE:   f_pattern = PAT_PRE;
      S_DATA:  f_pattern = PAT_DATA;
      S_POST:  f_pattern = PAT_POST;
      default: f_pattern = PAT_IDLE;
    endcase
  endfunction

  // r_cnt holds the tag of the cycle being entered at the next edge.
  assign w_cnt_p1     = r_cnt + CW'(1);
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_head_start = r_fifo_start[r_rd_ptr];
  assign w_head_bl32  = r_fifo_bl32[r_rd_ptr];
  assign w_head_now   = !w_empty && (w_head_start == r_cnt);
  assign w_head_next  = !w_empty && (w_head_start == w_cnt_p1);

  assign w_new_start  = r_cnt + CW'(i_wr_lat);
  assign w_new_end    = w_new_start + (i_bl32 ? CW'(3) : CW'(1));

  // Wrap-safe: the difference's top bit is the sign of (new start - last end).
  assign w_ovl_diff   = w_new_start - r_last_end;
  assign w_overlap    = r_last_vld && ((w_ovl_diff == '0) || w_ovl_diff[CW-1]);
  assign w_lat_bad    = (i_wr_lat < LAT_W'(2));
  assign w_reject     = i_wr_cmd && (w_lat_bad || (w_full && !w_pop) || w_overlap);
  assign w_push       = i_wr_cmd && !w_reject;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_head_next) w_state_nxt = S_PRE;
      end
      S_PRE: begin
        w_state_nxt = S_DATA;
        w_pop       = 1'b1;
      end
      S_DATA: begin
        if (r_beats_left == 2'd0) begin
          if (w_head_now) begin
            w_state_nxt = S_DATA;
            w_pop       = 1'b1;
          end else if (w_head_next) begin
            w_state_nxt = S_PRE;
          end else begin
            w_state_nxt = S_POST;
          end
        end
      end
      S_POST: begin
        w_state_nxt = w_head_next ? S_PRE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Entries popped this edge no longer count towards busy; pushes show up one cycle later.
  assign w_busy_nxt = (w_state_nxt != S_IDLE) || (r_count > (AW+1)'(w_pop));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_beats_left <= 2'd0;
      o_tx_dqs_sdr <= PAT_IDLE;
      o_dqs_oe     <= 1'b0;
      o_wrdata_en  <= 1'b0;
      o_busy       <= 1'b0;
      r_err_d      <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      if (w_pop) begin
        r_beats_left <= w_head_bl32 ? 2'd3 : 2'd1;
      end else if ((r_state == S_DATA) && (r_beats_left != 2'd0)) begin
        r_beats_left <= r_beats_left - 2'd1;
      end
      o_tx_dqs_sdr <= f_pattern(w_state_nxt);
      o_dqs_oe     <= (w_state_nxt != S_IDLE);
      o_wrdata_en  <= (w_state_nxt == S_DATA);
      o_busy       <= w_busy_nxt;
      r_err_d      <= w_reject;
      o_err        <= r_err_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_last_end <= '0;
      r_last_vld <= 1'b0;
    end else begin
      r_cnt <= w_cnt_p1;
      // Once fully idle the last end lies in the past; dropping it keeps a stale value
      // from aliasing into the future after the counter wraps.
      if (w_push) begin
        r_last_end <= w_new_end;
        r_last_vld <= 1'b1;
      end else if ((r_state == S_IDLE) && w_empty) begin
        r_last_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_start[i] <= '0;
        r_fifo_bl32[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_start[r_wr_ptr] <= w_new_start;
        r_fifo_bl32[r_wr_ptr]  <= i_bl32;
        r_wr_ptr               <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_dqs_wr_seq.sv
// Scoreboard bench for ddr_dqs_wr_seq: a cycle-indexed burst model predicts every output
// cycle; a monitor compares each cycle against the queued prediction.
module tb_ddr_dqs_wr_seq;
  localparam int LAT_W = 6;
  localparam int DEPTH = 4;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             wr_cmd = 1'b0;
  logic [LAT_W-1:0] wr_lat = '0;
  logic             bl32   = 1'b0;
  logic [7:0]       dqs;
  logic             oe;
  logic             wen;
  logic             busy;
  logic             err;

  always #5 clk = ~clk;

  ddr_dqs_wr_seq #(.LAT_W(LAT_W), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_cmd    (wr_cmd),
    .i_wr_lat    (wr_lat),
    .i_bl32      (bl32),
    .o_tx_dqs_sdr(dqs),
    .o_dqs_oe    (oe),
    .o_wrdata_en (wen),
    .o_busy      (busy),
    .o_err       (err)
  );

  typedef struct {int c; int s; int e;} burst_t;
  typedef struct {int t; logic [7:0] dqs; logic oe; logic wen; logic busy; logic err;} exp_t;

  burst_t bursts[$];
  exp_t   exp_q[$];
  int     cyc;
  int     last_end;
  int     last_rej;
  int     checks;
  int     errors;
  bit     mon_en;

  // Expected outputs in cycle t from the accepted bursts (absolute cycle numbers, no wrap).
  function automatic exp_t exp_at(int t);
    exp_t x;
    bit d, p, q, b;
    d = 0; p = 0; q = 0; b = 0;
    foreach (bursts[i]) begin
      if (t >= bursts[i].s && t <= bursts[i].e) d = 1;
      if (t == bursts[i].s - 1) p = 1;
      if (t == bursts[i].e + 1) q = 1;
      if (t >= bursts[i].c + 1 && t <= bursts[i].e + 1) b = 1;
    end
    x.t    = t;
    x.wen  = d;
    x.oe   = d | p | q;
    x.busy = b;
    x.err  = (last_rej == t - 1);
    x.dqs  = d ? 8'hAA : (p ? 8'hA0 : (q ? 8'h02 : 8'h00));
    return x;
  endfunction

  // Drives the inputs for edge E<cyc>, updates the model, queues the prediction for cycle cyc+1.
  task automatic step(bit cmd, int lat, bit b32);
    int s, e, occ;
    burst_t nb;
    wr_cmd = cmd;
    wr_lat = lat[LAT_W-1:0];
    bl32   = b32;
    if (cmd) begin
      s   = cyc + lat;
      e   = s + (b32 ? 4 : 2) - 1;
      occ = 0;
      foreach (bursts[i]) if (bursts[i].s > cyc) occ++;
      if (lat < 2 || occ >= DEPTH || s <= last_end) begin
        last_rej = cyc;
      end else begin
        nb.c = cyc; nb.s = s; nb.e = e;
        bursts.push_back(nb);
        last_end = e;
      end
    end
    exp_q.push_back(exp_at(cyc + 1));
    while (bursts.size() > 0 && bursts[0].e + 1 < cyc) void'(bursts.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic do_reset();
    exp_t x;
    mon_en = 0;
    rst_n  = 1'b0;
    wr_cmd = 1'b0;
    wr_lat = '0;
    bl32   = 1'b0;
    #1;
    checks++;
    if ({dqs, oe, wen, busy, err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got dqs=%h oe=%b wen=%b busy=%b err=%b, need all zero",
               dqs, oe, wen, busy, err);
    end
    exp_q.delete();
    bursts.delete();
    last_end = -1000;
    last_rej = -1000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    x = exp_at(0);
    exp_q.push_back(x);
    mon_en = 1;
  endtask

  task automatic cmp(string name, int t, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, t, got, want);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got output with no prediction, expected a queued entry");
        end else begin
          x = exp_q.pop_front();
          cmp("dqs_sdr",    x.t, dqs,         x.dqs);
          cmp("dqs_oe",     x.t, {7'd0, oe},   {7'd0, x.oe});
          cmp("wrdata_en",  x.t, {7'd0, wen},  {7'd0, x.wen});
          cmp("busy",       x.t, {7'd0, busy}, {7'd0, x.busy});
          cmp("err",        x.t, {7'd0, err},  {7'd0, x.err});
        end
      end
    end
  end

  initial begin : stimulus
    int r, lat;
    checks = 0;
    errors = 0;
    mon_en = 0;
    #3;

    do_reset();                       // single BL16, L=5
    step(1, 5, 0); idle(12);

    do_reset();                       // seamless BL16 + BL32
    step(1, 4, 0); idle(1); step(1, 4, 1); idle(14);

    do_reset();                       // gap of one cycle: preamble replaces postamble
    step(1, 4, 0); idle(2); step(1, 4, 0); idle(12);

    do_reset();                       // latency too small
    step(1, 1, 0); idle(3); step(1, 0, 1); idle(6);

    do_reset();                       // overlap rejected, first burst intact
    step(1, 4, 1); step(1, 4, 0); idle(12);

    do_reset();                       // queue full
    repeat (4) step(1, 40, 0);
    step(1, 40, 0); idle(60);

    do_reset();                       // full queue with a pop on the same edge
    step(1, 10, 0); step(1, 12, 0); step(1, 13, 0); step(1, 15, 0);
    idle(6); step(1, 10, 0); idle(20);

    do_reset();                       // reset in the middle of a data cycle
    step(1, 5, 0); idle(5);
    do_reset();
    idle(20);

    do_reset();                       // random traffic
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        r = $urandom_range(0, 99);
        if (r < 10)      lat = $urandom_range(0, 1);
        else if (r < 80) lat = $urandom_range(2, 10);
        else             lat = $urandom_range(2, 50);
        step(1, lat, 1'($urandom_range(0, 1)));
      end else begin
        step(0, 0, 0);
      end
    end
    idle(60);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
